// File: rtl/sdram_arbit_rr_if.sv
// sdram_arbit_rr_if: bundles the init, refresh, user-channel and SDRAM pad buses of the round-robin SDRAM arbiter.
// Ports (arbiter view, slave modport):
//   init_*      : init sequencer command bus and init-complete level
//   ref_*       : refresh request/end handshake, refresh command bus, ref_en_o grant
//   ch_*        : per-channel request/end, flattened command/ba/addr/write-data buses, one-hot grant
//   rd_data_o   : SDRAM read data broadcast to all channels
//   wdog_err_o  : grant watchdog timeout pulse
//   sdram_*     : SDRAM pad-ring command/address/DQ signals
// The master modport is the mirror image, for whatever drives the arbiter.
interface sdram_arbit_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic [3:0]             init_cmd_i;
    logic [BA_W-1:0]        init_ba_i;
    logic [ADDR_W-1:0]      init_addr_i;
    logic                   init_end_i;
    logic                   ref_req_i;
    logic                   ref_end_i;
    logic [3:0]             ref_cmd_i;
    logic [BA_W-1:0]        ref_ba_i;
    logic [ADDR_W-1:0]      ref_addr_i;
    logic                   ref_en_o;
    logic [NUM_CH-1:0]      ch_req_i;
    logic [NUM_CH-1:0]      ch_end_i;
    logic [4*NUM_CH-1:0]    ch_cmd_i;
    logic [BA_W*NUM_CH-1:0] ch_ba_i;
    logic [ADDR_W*NUM_CH-1:0] ch_addr_i;
    logic [NUM_CH-1:0]      ch_dq_en_i;
    logic [DQ_W*NUM_CH-1:0] ch_dq_i;
    logic [NUM_CH-1:0]      ch_grant_o;
    logic [DQ_W-1:0]        rd_data_o;
    logic                   wdog_err_o;
    logic                   sdram_cke_o;
    logic                   sdram_cs_n_o;
    logic                   sdram_ras_n_o;
    logic                   sdram_cas_n_o;
    logic                   sdram_we_n_o;
    logic [BA_W-1:0]        sdram_ba_o;
    logic [ADDR_W-1:0]      sdram_addr_o;
    logic                   sdram_dq_en_o;
    logic [DQ_W-1:0]        sdram_dq_o;
    logic [DQ_W-1:0]        sdram_dq_i;

    modport slave (
        input  init_cmd_i, init_ba_i, init_addr_i, init_end_i,
        input  ref_req_i, ref_end_i, ref_cmd_i, ref_ba_i, ref_addr_i,
        output ref_en_o,
        input  ch_req_i, ch_end_i, ch_cmd_i, ch_ba_i, ch_addr_i, ch_dq_en_i, ch_dq_i,
        output ch_grant_o, rd_data_o, wdog_err_o,
        output sdram_cke_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
        output sdram_ba_o, sdram_addr_o, sdram_dq_en_o, sdram_dq_o,
        input  sdram_dq_i
    );

    modport master (
        output init_cmd_i, init_ba_i, init_addr_i, init_end_i,
        output ref_req_i, ref_end_i, ref_cmd_i, ref_ba_i, ref_addr_i,
        input  ref_en_o,
        output ch_req_i, ch_end_i, ch_cmd_i, ch_ba_i, ch_addr_i, ch_dq_en_i, ch_dq_i,
        input  ch_grant_o, rd_data_o, wdog_err_o,
        input  sdram_cke_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
        input  sdram_ba_o, sdram_addr_o, sdram_dq_en_o, sdram_dq_o,
        output sdram_dq_i
    );
endinterface

// File: rtl/sdram_arbit_rr.sv
// sdram_arbit_rr: multiplexes init, auto-refresh and NUM_CH round-robin user channels onto one SDRAM bus.
// Ports:
//   sys_clk_i : system clock
//   rst_i     : asynchronous active-high reset
//   bus       : sdram_arbit_rr_if.slave carrying all init/refresh/channel/SDRAM signals
// Refresh always wins arbitration; every grant is preceded by at least one NOP (ARBIT) cycle.
// Optional macro SDRAM_ARB_WDOG_EN adds a grant watchdog of WDOG_CYC cycles; otherwise wdog_err_o is 0.
module sdram_arbit_rr #(
    parameter int NUM_CH   = 4,
    parameter int DQ_W     = 16,
    parameter int ADDR_W   = 13,
    parameter int BA_W     = 2,
    parameter int WDOG_CYC = 1024
) (
    input logic              sys_clk_i,
    input logic              rst_i,
    sdram_arbit_rr_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [3:0] NOP = 4'b0111;

    typedef enum logic [1:0] {IDLE, ARBIT, REFRESH, CHAN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, act_ch_q, act_ch_d, pick;
    logic               found, end_now, timeout;
    logic [3:0]         cmd;
    logic [BA_W-1:0]    ba;
    logic [ADDR_W-1:0]  addr;
    logic [NUM_CH-1:0]  grant;
    logic               ref_en, dq_en;
    logic [DQ_W-1:0]    dq;

    // Scan from the highest offset down so the channel closest to rr_ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_req_i[(int'(rr_ptr_q) + i) % NUM_CH]) begin
                found = 1'b1;
                pick  = PTR_W'((int'(rr_ptr_q) + i) % NUM_CH);
            end
        end
    end

    assign end_now = (state_q == REFRESH) ? bus.ref_end_i : bus.ch_end_i[act_ch_q];

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            wdog_err_q;
    wire busy = (state_q == REFRESH) || (state_q == CHAN);
    // An end pulse coinciding with the timeout is a normal end, not an error.
    assign timeout = busy && (wdog_q == WD_W'(WDOG_CYC - 1)) && !end_now;
    assign wdog_d  = busy ? wdog_q + 1'b1 : '0;
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= timeout;
        end
    end
    assign bus.wdog_err_o = wdog_err_q;
`else
    assign timeout        = 1'b0;
    assign bus.wdog_err_o = 1'b0;
`endif

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            act_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            act_ch_q <= act_ch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        act_ch_d = act_ch_q;
        cmd      = NOP;
        ba       = '1;
        addr     = '1;
        grant    = '0;
        ref_en   = 1'b0;
        dq_en    = 1'b0;
        dq       = '0;
        case (state_q)
            IDLE: begin
                cmd  = bus.init_cmd_i;
                ba   = bus.init_ba_i;
                addr = bus.init_addr_i;
                if (bus.init_end_i) state_d = ARBIT;
            end
            ARBIT: begin
                if (bus.ref_req_i) begin
                    state_d = REFRESH;
                end else if (found) begin
                    state_d  = CHAN;
                    act_ch_d = pick;
                    rr_ptr_d = (pick == PTR_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
                end
            end
            REFRESH: begin
                cmd    = bus.ref_cmd_i;
                ba     = bus.ref_ba_i;
                addr   = bus.ref_addr_i;
                ref_en = 1'b1;
                if (end_now || timeout) state_d = ARBIT;
            end
            CHAN: begin
                cmd             = bus.ch_cmd_i[4*act_ch_q +: 4];
                ba              = bus.ch_ba_i[BA_W*act_ch_q +: BA_W];
                addr            = bus.ch_addr_i[ADDR_W*act_ch_q +: ADDR_W];
                grant[act_ch_q] = 1'b1;
                dq_en           = bus.ch_dq_en_i[act_ch_q];
                dq              = dq_en ? bus.ch_dq_i[DQ_W*act_ch_q +: DQ_W] : '0;
                if (end_now || timeout) state_d = ARBIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sdram_cke_o   = 1'b1;
    assign bus.sdram_cs_n_o  = cmd[3];
    assign bus.sdram_ras_n_o = cmd[2];
    assign bus.sdram_cas_n_o = cmd[1];
    assign bus.sdram_we_n_o  = cmd[0];
    assign bus.sdram_ba_o    = ba;
    assign bus.sdram_addr_o  = addr;
    assign bus.sdram_dq_en_o = dq_en;
    assign bus.sdram_dq_o    = dq;
    assign bus.ch_grant_o    = grant;
    assign bus.ref_en_o      = ref_en;
    assign bus.rd_data_o     = bus.sdram_dq_i;
endmodule

// File: doc/sdram_arbit_rr.md
Name: sdram_arbit_rr

Overview:
Parametrised successor to the single-write/single-read SDRAM arbiter. It multiplexes an init sequencer, an auto-refresh engine and NUM_CH generic user channels onto one SDRAM command/address/DQ interface. User channels are served by a round-robin pointer; refresh always wins. It sits between the per-channel burst controllers and the SDRAM pad ring.

Parameters:
NUM_CH, 4, number of user channels (2..8)
DQ_W, 16, SDRAM data width
ADDR_W, 13, SDRAM address width
BA_W, 2, bank address width
WDOG_CYC, 1024, max cycles a grant may be held (used only with the optional feature)

Ports:
sys_clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
init_cmd_i  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_ba_i  in  BA_W  init bank address
init_addr_i  in  ADDR_W  init address
init_end_i  in  1  init complete (level)
ref_req_i  in  1  auto-refresh request
ref_end_i  in  1  refresh sequence done (1-cycle pulse)
ref_cmd_i / ref_ba_i / ref_addr_i  in  4 / BA_W / ADDR_W  refresh command bus
ref_en_o  out  1  refresh granted
ch_req_i  in  NUM_CH  per-channel request
ch_end_i  in  NUM_CH  per-channel burst done (pulse)
ch_cmd_i  in  4*NUM_CH  channel k uses bits [4k+3:4k]
ch_ba_i  in  BA_W*NUM_CH  flattened bank addresses
ch_addr_i  in  ADDR_W*NUM_CH  flattened addresses
ch_dq_en_i  in  NUM_CH  channel drives DQ (write phase)
ch_dq_i  in  DQ_W*NUM_CH  flattened write data
ch_grant_o  out  NUM_CH  one-hot grant
rd_data_o  out  DQ_W  sdram_dq_i broadcast to all channels
wdog_err_o  out  1  watchdog timeout pulse
sdram_cke_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o  out  1 each
sdram_ba_o  out  BA_W;  sdram_addr_o  out  ADDR_W
sdram_dq_en_o  out  1;  sdram_dq_o  out  DQ_W;  sdram_dq_i  in  DQ_W

Behaviour:
- States: IDLE, ARBIT, REFRESH, CHAN. Registered state, pointer rr_ptr (log2 NUM_CH bits), active-channel index act_ch.
- Reset (async, immediate, also mid-burst): state=IDLE, rr_ptr=0, act_ch=0. Outputs during reset: command/ba/addr follow init_* inputs; ch_grant_o=0, ref_en_o=0, sdram_dq_en_o=0, sdram_dq_o=0, wdog_err_o=0, sdram_cke_o=1.
- IDLE -> ARBIT when init_end_i=1; init_end_i is ignored in every other state.
- ARBIT: drive NOP (4'b0111), ba all-ones, addr all-ones. Priority: ref_req_i -> REFRESH; else the first set ch_req_i bit searching k = rr_ptr, rr_ptr+1, ... (mod NUM_CH) -> CHAN with act_ch=k, rr_ptr=(k+1) mod NUM_CH. No request: stay.
- Every grant costs at least one ARBIT (NOP) cycle; back-to-back grants are never issued.
- REFRESH: mux ref_* bus, ref_en_o=1. ref_end_i -> ARBIT next cycle.
- CHAN: mux channel act_ch bus, ch_grant_o[act_ch]=1. ch_end_i[act_ch] -> ARBIT next cycle. ch_end_i on other channels is ignored. ref_req_i does not pre-empt; it waits for the ARBIT cycle.
- Grant latency: request seen in ARBIT at cycle t -> grant/en high at t+1. Deassertion follows end pulse by exactly 1 cycle.
- sdram_dq_en_o = ch_dq_en_i[act_ch] only in CHAN, else 0. sdram_dq_o = selected data when enabled, else 0.
- All mux outputs are combinational from registered state and act_ch.
- Out-of-range act_ch is impossible by construction; illegal state encodings default to IDLE with NOP.

Optional Feature:
SDRAM_ARB_WDOG_EN: when defined, a counter clears on entry to REFRESH/CHAN and increments each cycle there. If it reaches WDOG_CYC-1 without the end pulse, the block forces ARBIT on the next cycle and pulses wdog_err_o high for 1 cycle. An end pulse in the same cycle as the timeout counts as a normal end, with no error. When not defined: no counter, and wdog_err_o is tied 0.

Test Plan:
- Reset mid-CHAN (ch 2 granted) with rst_i pulse -> grant drops in the same cycle; state=IDLE; cmd follows init_cmd_i; rr_ptr=0.
- init_end_i=1, all four ch_req_i=1 held -> grants in order 0,1,2,3,0, each separated by one NOP cycle; each ch_end_i pulse is followed by 1-cycle grant release.
- ref_req_i and ch_req_i[1] asserted together in ARBIT -> ref_en_o=1 first; after ref_end_i, ch 1 is granted following one NOP.
- ref_req_i raised while ch 3 is active -> ch 3 keeps its grant until ch_end_i[3]; REFRESH follows one ARBIT cycle later; a stray ch_end_i[0] during this is ignored.
- ch 0 write with ch_dq_en_i[0]=1, data 16'hA5A5 -> sdram_dq_en_o=1, sdram_dq_o=16'hA5A5; 0/16'h0000 in ARBIT.
- With SDRAM_ARB_WDOG_EN, WDOG_CYC=16, ch 1 never ends -> the grant holds for 16 cycles, then wdog_err_o pulses once and the next request is arbitrated.
